// File: rtl/hazard_interlock_unit.sv
// RAW-hazard interlock for the 5-stage RV32I core, with an EX/MEM/WB destination scoreboard and ECALL halt sequencing.
// Optional: define HAZARD_FORWARDING_EN when the datapath has EX/MEM and MEM/WB forwarding paths.
module hazard_interlock_unit #(
   parameter int NUM_REGS     = 32,
   parameter bit RF_BYPASS    = 1'b1,
   parameter int DRAIN_CYCLES = 3,
   localparam int RW          = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic          id_use_rs1,
   input  logic          id_use_rs2,
   input  logic [RW-1:0] id_rd,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_is_ecall,
   input  logic          halt_req,
   input  logic          ex_flush,
   output logic          stall,
   output logic          pc_write,
   output logic          if_id_write,
   output logic          if_id_flush,
   output logic          id_ex_bubble,
   output logic          is_halted,
   output logic [31:0]   stall_count
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [RW-1:0] ECALL_SRC  = RW'(17);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rd;
      logic          is_load;
   } slot_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] drain_cnt, drain_cnt_nxt;
   slot_t         ex_slot, mem_slot, wb_slot, ex_slot_nxt;
   logic          hazard;

   // A valid slot never holds x0, so an x0 source can never hit.
   function automatic logic hit(input slot_t s, input logic [RW-1:0] r);
      return s.valid && (s.rd == r);
   endfunction

   function automatic logic raw_hit(input slot_t ex, input slot_t mem, input slot_t wb,
                                    input logic [RW-1:0] r);
      return hit(ex, r) || hit(mem, r) || (!RF_BYPASS && hit(wb, r));
   endfunction

   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
      hazard = 1'b0;
`ifdef HAZARD_FORWARDING_EN
      hazard = ex_slot.is_load &&
               ((id_use_rs1 && hit(ex_slot, id_rs1)) || (id_use_rs2 && hit(ex_slot, id_rs2)));
      // The x17 halt compare happens in ID, so forwarding cannot help it.
      if (id_is_ecall)
         hazard = hazard || hit(ex_slot, ECALL_SRC) ||
                  (mem_slot.is_load && hit(mem_slot, ECALL_SRC)) ||
                  (!RF_BYPASS && hit(wb_slot, ECALL_SRC));
`else
      hazard = (id_use_rs1  && raw_hit(ex_slot, mem_slot, wb_slot, id_rs1)) ||
               (id_use_rs2  && raw_hit(ex_slot, mem_slot, wb_slot, id_rs2)) ||
               (id_is_ecall && raw_hit(ex_slot, mem_slot, wb_slot, ECALL_SRC));
`endif
   end

   assign stall = id_valid && hazard && !ex_flush && (state == RUN);

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      is_halted     = 1'b0;
      case (state)
         RUN: begin
            drain_cnt_nxt = '0;
            if (ex_flush) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (stall) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
            end else if (halt_req && id_valid) begin
               state_nxt = DRAIN;
            end
         end
         // ex_flush is ignored here: the halting ECALL is older than any flush source.
         DRAIN: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (drain_cnt == DRAIN_LAST) state_nxt = HALTED;
            else                         drain_cnt_nxt = drain_cnt + 1'b1;
         end
         HALTED: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            is_halted    = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      ex_slot_nxt = '0;
      if (id_valid && !stall && !ex_flush && (state == RUN)) begin
         ex_slot_nxt.valid   = id_reg_write && (id_rd != '0);
         ex_slot_nxt.rd      = id_rd;
         ex_slot_nxt.is_load = id_mem_read;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so the WB<=MEM<=EX shift reads pre-edge values.
   // NOTE: the scoreboard slots are reset because their valid bits gate every hazard match.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         drain_cnt   <= '0;
         ex_slot     <= '0;
         mem_slot    <= '0;
         wb_slot     <= '0;
         stall_count <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         wb_slot   <= mem_slot;
         mem_slot  <= ex_slot;
         ex_slot   <= ex_slot_nxt;
         if (stall) stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Self-checking bench for hazard_interlock_unit: directed pipeline scenarios plus randomized traffic
// checked against an issue-history reference model.
module tb_hazard_interlock_unit;

   localparam int NUM_REGS     = 32;
   localparam bit RF_BYPASS    = 1'b1;
   localparam int DRAIN_CYCLES = 3;

`ifdef HAZARD_FORWARDING_EN
   localparam int EXP_RAW = 0, EXP_LOAD_USE = 1, EXP_HALT = 1;
`else
   localparam int EXP_RAW = 2, EXP_LOAD_USE = 2, EXP_HALT = 2;
`endif

   logic        clk, reset;
   logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic        id_is_ecall, halt_req, ex_flush;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
   logic [31:0] stall_count;

   int total = 0;
   int bad   = 0;

   hazard_interlock_unit #(
      .NUM_REGS(NUM_REGS), .RF_BYPASS(RF_BYPASS), .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_ecall(id_is_ecall),
      .halt_req(halt_req), .ex_flush(ex_flush), .stall(stall), .pc_write(pc_write),
      .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .is_halted(is_halted), .stall_count(stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: history of what was issued into EX ----------------
   typedef struct {int rd; bit ld;} ent_t;
   ent_t      hist[$];        // hist[0] issued 1 cycle ago, hist[1] 2 cycles ago, ...
   int        m_state;        // 0 run, 1 drain, 2 halted
   int        m_cnt;
   bit [31:0] m_stalls;

   function automatic void model_clear();
      hist.delete();
      m_state  = 0;
      m_cnt    = 0;
      m_stalls = '0;
   endfunction

   function automatic bit src_hazard(int s, bit is_ecall_src);
      if (s == 0) return 1'b0;
      foreach (hist[a]) begin
         int age = a + 1;
         if (hist[a].rd == s) begin
`ifdef HAZARD_FORWARDING_EN
            if (!is_ecall_src && age == 1 && hist[a].ld) return 1'b1;
            if (is_ecall_src && (age == 1 || (age == 2 && hist[a].ld) || (age == 3 && !RF_BYPASS)))
               return 1'b1;
`else
            if (age <= 2 || (age == 3 && !RF_BYPASS)) return 1'b1;
`endif
         end
      end
      return 1'b0;
   endfunction

   function automatic bit model_stall();
      bit hz;
      hz = (id_use_rs1 && src_hazard(int'(id_rs1), 1'b0)) ||
           (id_use_rs2 && src_hazard(int'(id_rs2), 1'b0)) ||
           (id_is_ecall && src_hazard(17, 1'b1));
      return id_valid && hz && !ex_flush && (m_state == 0);
   endfunction

   // {stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted}
   function automatic logic [5:0] model_eval();
      bit st = model_stall();
      logic [5:0] e = 6'b011000;
      if (m_state == 0) begin
         if (ex_flush) e = 6'b011110;
         else if (st)  e = 6'b100010;
      end else if (m_state == 1) begin
         e = 6'b000010;
      end else begin
         e = 6'b000011;
      end
      return e;
   endfunction

   function automatic void model_step();
      bit   st = model_stall();
      ent_t e;
      e.rd = (st || ex_flush || !id_valid || m_state != 0 || !id_reg_write) ? 0 : int'(id_rd);
      e.ld = id_mem_read;
      if (m_state == 0) begin
         if (halt_req && id_valid && !st && !ex_flush) begin
            m_state = 1;
            m_cnt   = 0;
         end
      end else if (m_state == 1) begin
         if (m_cnt == DRAIN_CYCLES - 1) m_state = 2;
         else                           m_cnt++;
      end
      if (st) m_stalls++;
      hist.push_front(e);
      if (hist.size() > 3) void'(hist.pop_back());
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit ld);
      id_valid     = v;
      id_rd        = 5'(rd);
      id_rs1       = 5'(rs1);
      id_rs2       = 5'(rs2);
      id_use_rs1   = u1;
      id_use_rs2   = u2;
      id_reg_write = rw;
      id_mem_read  = ld;
      id_is_ecall  = 1'b0;
      halt_req     = 1'b0;
      ex_flush     = 1'b0;
   endtask

   task automatic do_reset();
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 9) == 0) return 5'd17;
      return 5'($urandom_range(0, 7));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++; if (stall !== 1'b0)        begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      total++; if (pc_write !== 1'b1)     begin bad++; $display("FAIL reset_pc_write: got %b want 1", pc_write); end
      total++; if (if_id_write !== 1'b1)  begin bad++; $display("FAIL reset_if_id_write: got %b want 1", if_id_write); end
      total++; if (if_id_flush !== 1'b0)  begin bad++; $display("FAIL reset_if_id_flush: got %b want 0", if_id_flush); end
      total++; if (id_ex_bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble: got %b want 0", id_ex_bubble); end
      total++; if (is_halted !== 1'b0)    begin bad++; $display("FAIL reset_halted: got %b want 0", is_halted); end
      total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", stall_count); end
      tick();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_reset();
      set_id(1'b1, 5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0);   // add x5,x1,x2
      tick();
      set_id(1'b1, 6, 5, 3, 1'b1, 1'b1, 1'b1, 1'b0);   // sub x6,x5,x3
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         total++;
         if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0)
            begin bad++; $display("FAIL raw_stall_ctrl: got bubble=%b pc=%b want 1 0", id_ex_bubble, pc_write); end
         tick();
      end
      total++; if (n != EXP_RAW) begin bad++; $display("FAIL raw_stall_cycles: got %0d want %0d", n, EXP_RAW); end
      total++; if (stall_count !== 32'(EXP_RAW))
         begin bad++; $display("FAIL raw_stall_count: got %0d want %0d", stall_count, EXP_RAW); end
      tick();
   endtask

   task automatic test_load_use();
      int n = 0;
      do_reset();
      set_id(1'b1, 7, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x7,0(x1)
      tick();
      set_id(1'b1, 8, 7, 7, 1'b1, 1'b1, 1'b1, 1'b0);   // add x8,x7,x7
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         tick();
      end
      total++; if (n != EXP_LOAD_USE) begin bad++; $display("FAIL load_use_cycles: got %0d want %0d", n, EXP_LOAD_USE); end
      tick();
      do_reset();
      n = 0;
      set_id(1'b1, 7, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x7,0(x1)
      tick();
      set_id(1'b1, 8, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0);   // add x8,x1,x1
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         tick();
      end
      total++; if (n != 0) begin bad++; $display("FAIL independent_cycles: got %0d want 0", n); end
      tick();
   endtask

   task automatic test_x0();
      do_reset();
      set_id(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // write to x0 (as a load, to cover both builds)
      tick();
      set_id(1'b1, 3, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);   // add x3,x0,x0
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall cycle %0d: got %b want 0", c, stall); end
         tick();
      end
   endtask

   task automatic test_flush_collision();
      do_reset();
      set_id(1'b1, 5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0);   // add x5
      tick();
      set_id(1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x6,0(x5), killed by the flush
      ex_flush = 1'b1;
      @(negedge clk);
      total++; if (stall !== 1'b0)        begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
      total++; if (if_id_flush !== 1'b1)  begin bad++; $display("FAIL flush_if_id_flush: got %b want 1", if_id_flush); end
      total++; if (pc_write !== 1'b1)     begin bad++; $display("FAIL flush_pc_write: got %b want 1", pc_write); end
      total++; if (if_id_write !== 1'b1)  begin bad++; $display("FAIL flush_if_id_write: got %b want 1", if_id_write); end
      total++; if (id_ex_bubble !== 1'b1) begin bad++; $display("FAIL flush_bubble: got %b want 1", id_ex_bubble); end
      tick();
      set_id(1'b1, 9, 6, 0, 1'b1, 1'b0, 1'b1, 1'b0);   // reads x6: must not see the flushed load
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_ex_invalid: got stall=%b want 0", stall); end
      tick();
   endtask

   task automatic test_halt();
      int n = 0;
      do_reset();
      set_id(1'b1, 17, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);  // addi x17,x0,10
      tick();
      set_id(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // ecall
      id_is_ecall = 1'b1;
      halt_req    = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         tick();
      end
      total++; if (n != EXP_HALT) begin bad++; $display("FAIL halt_stall_cycles: got %0d want %0d", n, EXP_HALT); end
      tick();
      ex_flush = 1'b1;
      for (int c = 0; c < DRAIN_CYCLES; c++) begin
         @(negedge clk);
         total++;
         if ({stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted} !== 6'b000010)
            begin bad++; $display("FAIL drain_ctrl cycle %0d: got %b want 000010", c,
                                  {stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted}); end
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted} !== 6'b000011)
            begin bad++; $display("FAIL halted_ctrl cycle %0d: got %b want 000011", c,
                                  {stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted}); end
         set_id(1'b1, 17, 17, 17, 1'b1, 1'b1, 1'b1, 1'b1);
         ex_flush = 1'(c % 2);
         tick();
      end
      #2;
      reset = 1'b0;
      #1;
      total++; if (is_halted !== 1'b0) begin bad++; $display("FAIL halt_cleared_by_reset: got %b want 0", is_halted); end
   endtask

   task automatic test_reset_in_drain();
      do_reset();
      set_id(1'b1, 17, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      id_is_ecall = 1'b1;
      halt_req    = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!stall) break;
         tick();
      end
      tick();                                          // DRAIN entry
      tick();                                          // one cycle into DRAIN
      total++; if (pc_write !== 1'b0 || stall_count !== 32'(EXP_HALT))
         begin bad++; $display("FAIL pre_reset_drain: got pc=%b count=%0d want 0 %0d", pc_write, stall_count, EXP_HALT); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (is_halted !== 1'b0)    begin bad++; $display("FAIL drain_reset_halted: got %b want 0", is_halted); end
      total++; if (pc_write !== 1'b1)     begin bad++; $display("FAIL drain_reset_pc_write: got %b want 1", pc_write); end
      total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL drain_reset_count: got %0d want 0", stall_count); end
      total++; if (id_ex_bubble !== 1'b0) begin bad++; $display("FAIL drain_reset_bubble: got %b want 0", id_ex_bubble); end
   endtask

   task automatic test_random();
      logic [5:0] want;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         id_valid     = ($urandom_range(0, 7) != 0);
         id_rs1       = pick_reg();
         id_rs2       = pick_reg();
         id_rd        = pick_reg();
         id_use_rs1   = 1'($urandom_range(0, 1));
         id_use_rs2   = 1'($urandom_range(0, 1));
         id_reg_write = 1'($urandom_range(0, 1));
         id_mem_read  = 1'($urandom_range(0, 1));
         id_is_ecall  = ($urandom_range(0, 9) == 0);
         halt_req     = id_is_ecall && ($urandom_range(0, 2) == 0);
         ex_flush     = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         want = model_eval();
         total++;
         if ({stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted} !== want)
            begin bad++; $display("FAIL rand_ctrl cycle %0d: got %b want %b", c,
                                  {stall, pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted}, want); end
         total++;
         if (stall_count !== m_stalls)
            begin bad++; $display("FAIL rand_count cycle %0d: got %0d want %0d", c, stall_count, m_stalls); end
         tick();
         if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      reset = 1'b1;
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_x0();
      test_flush_collision();
      test_halt();
      test_reset_in_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_interlock_unit.md
Name: hazard_interlock_unit

Overview:
- Produces the `stall` and pipeline-write-enable signals consumed by the control unit and the pipeline registers of the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers in an internal 3-slot scoreboard (EX, MEM, WB) and detects RAW hazards for the instruction in ID.
- Sequences the ECALL halt: drains the pipeline, then raises a sticky `is_halted`.

Parameters:
- NUM_REGS, 32, architectural register count; index width is clog2(NUM_REGS).
- RF_BYPASS, 1, 1 = register file forwards a same-cycle WB write to the ID read, so the WB slot never causes a hazard. 0 = WB slot matches also stall.
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  instruction in ID reads rs1
- id_use_rs2  in  1  instruction in ID reads rs2
- id_rd  in  5  ID destination register
- id_reg_write  in  1  instruction in ID writes rd (unstalled control value)
- id_mem_read  in  1  instruction in ID is a load
- id_is_ecall  in  1  instruction in ID is ECALL (reads x17)
- halt_req  in  1  halt condition evaluated in ID (ECALL with x17 == 10)
- ex_flush  in  1  taken branch/jump resolved in EX
- stall  out  1  hold ID; zero the control signals of the ID instruction
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  kill the IF/ID contents
- id_ex_bubble  out  1  load a bubble into ID/EX
- is_halted  out  1  sticky halt
- stall_count  out  32  cycles in which stall was 1

Behaviour:
- Reset (async, reset == 0):
  - Scoreboard slots invalid; FSM in RUN; stall_count = 0.
  - Outputs: stall = 0, pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0, is_halted = 0.
- Scoreboard: each slot holds {valid, rd, is_load}. Updated on every posedge in RUN:
  - WB <= MEM
  - MEM <= EX
  - EX <= bubble (valid = 0) if stall, ex_flush, or !id_valid.
  - Otherwise EX <= {id_reg_write && id_rd != 0, id_rd, id_mem_read}.
- Match for register r in a slot: slot valid and slot.rd == r. A source counts only if its id_use_* bit is 1; ECALL adds an implicit source r = 17.
- Hazard without forwarding (combinational):
  - Any ID source matches the EX or MEM slot.
  - Or any ID source matches the WB slot when RF_BYPASS == 0.
- stall = id_valid && hazard && !ex_flush && state == RUN.
- On stall: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
- ex_flush has priority over stall:
  - if_id_flush = 1 and id_ex_bubble = 1.
  - pc_write = 1 and if_id_write = 1.
  - stall = 0.
- stall_count increments by 1 each cycle stall == 1; wraps from 0xFFFFFFFF to 0.
- FSM states:
  - RUN -> DRAIN when halt_req && id_valid && !stall && !ex_flush.
  - DRAIN: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; the internal counter counts DRAIN_CYCLES posedges. The scoreboard keeps shifting, so older instructions retire.
  - DRAIN -> HALTED when the counter reaches DRAIN_CYCLES - 1.
  - HALTED: is_halted = 1, all enables 0, id_ex_bubble = 1, stall = 0. Left only by reset.
- ex_flush during DRAIN is ignored: the halting ECALL is older than anything that could flush.
- Reset mid-DRAIN returns to RUN with the scoreboard cleared.
- rd == 0 never enters the scoreboard. Sources equal to x0 never match.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined (EX/MEM and MEM/WB forwarding paths exist in the datapath):
  - An ordinary source stalls only when it matches the EX slot and EX.is_load == 1 (load-use, 1 bubble).
  - The ECALL x17 source still stalls on any EX match, or a MEM match with is_load, because the halt compare happens in ID.
- Undefined: the full non-forwarding rule above applies.

Test Plan:
- Back-to-back dependency, no forwarding: `add x5,x1,x2` then `sub x6,x5,x3` -> stall = 1 for exactly 2 cycles with id_ex_bubble = 1; stall_count = 2.
- Load-use with HAZARD_FORWARDING_EN: `lw x7,0(x1)` then `add x8,x7,x7` -> exactly 1 stall cycle. An independent `add x8,x1,x1` -> 0 stall cycles.
- x0 destination: `addi x0,x0,1` then `add x3,x0,x0` -> stall never asserts.
- Flush-versus-stall collision: hazard present in ID while ex_flush = 1 in the same cycle -> stall = 0, if_id_flush = 1, pc_write = 1; the EX slot becomes invalid next cycle.
- Halt: `addi x17,x0,10`, `ecall` -> stall until x17 has retired past MEM. Then halt_req is accepted, DRAIN lasts 3 cycles, is_halted = 1 on the 4th cycle and stays high until reset goes low.
- Reset during DRAIN: reset driven low 1 cycle after DRAIN entry -> is_halted = 0, pc_write = 1, stall_count = 0 immediately, without waiting for a clock edge.
